window_gen_3x3: RTL and testbench
=================================

Name: window_gen_3x3

Overview:
Streaming 3x3 neighbourhood generator that sits directly upstream of the 3x3 sorting window in the median filter path. It accepts one 8-bit raster-order pixel per valid cycle and stores the two previous image lines in line buffers. It presents the nine pixels of each complete 3x3 window, registered, with a valid strobe and the window-centre coordinates. Border pixels without a full neighbourhood produce no window.

Parameters:
IMG_WIDTH, 640, pixels per line (min 3)
IMG_HEIGHT, 480, lines per frame (min 3)
DATA_W, 8, pixel width in bits
CW, $clog2(IMG_WIDTH), column counter and win_col width (derived)
RW, $clog2(IMG_HEIGHT), row counter and win_row width (derived)

Ports:
clk  in  1  system clock; all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
pix_in  in  DATA_W  input pixel, raster order
pix_valid  in  1  pix_in valid this cycle; no backpressure, the block always accepts
sof  in  1  start of frame; qualified by pix_valid, marks the pixel as (0,0)
w11,w12,w13  out  DATA_W  top window row, left to right (line r-2)
w21,w22,w23  out  DATA_W  middle window row (line r-1)
w31,w32,w33  out  DATA_W  bottom window row (current line r)
win_valid  out  1  window outputs valid; one-cycle strobe per window
win_row  out  RW  centre row of the presented window (r-1)
win_col  out  CW  centre column of the presented window (c-1)
frame_done  out  1  one-cycle pulse coincident with the last window of a frame

Behaviour:
- Reset (rst_n low, asynchronous): row/col counters=0; w11..w33=0; win_valid=0; win_row=win_col=0; frame_done=0. Line-buffer RAM contents are not reset; the first two lines never produce windows.
- Accept: a cycle with pix_valid=1. Position (r,c) is the counter value, or (0,0) if sof=1.
- On accept at column c:
  - lb1[c] is read (pixel (r-1,c)) and lb2[c] is read (pixel (r-2,c)).
  - lb2[c] <= old lb1[c]; lb1[c] <= pix_in. Read-before-write at the same address.
  - Column shift: w11<=w12, w12<=w13, w13<=lb2 out; w21<=w22, w22<=w23, w23<=lb1 out; w31<=w32, w32<=w33, w33<=pix_in.
- Latency: window outputs, win_valid, win_row, win_col and frame_done update on the clock edge that accepts the pixel. They are visible one cycle after pix_valid.
- win_valid: set to 1 on accept when r>=2 and c>=2, else 0. Forced to 0 on any cycle with pix_valid=0.
- While pix_valid=0, the window registers and coordinates hold their value.
- Windows per frame: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2). Stale columns from the previous line are masked by the c>=2 gate.
- Counters:
  - col increments per accept and wraps IMG_WIDTH-1 -> 0 with row+1.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0. frame_done=1 alongside that window (win_valid=1).
- sof with pix_valid: counters are forced so this pixel is (0,0) and the next pixel is (0,1). This holds mid-frame and overrides a wrap in the same cycle. The partial frame produces no frame_done.
- sof without pix_valid is ignored.
- Line buffers: one-read/one-write per cycle, depth IMG_WIDTH, inferable as block RAM or shift-register RAM. They need no combinational path from the read to pix_in.
- Reset mid-frame: the next accepted pixel is (0,0). No window is emitted until (2,2) of the new frame.

Test Plan:
- Setup for all directed tests: IMG_WIDTH=8, IMG_HEIGHT=6, pixel value = row*16+col.
- Continuous frame, sof on the first pixel -> first win_valid one cycle after pixel (2,2).
  - That window: w11..w13=00,01,02; w21..w23=10,11,12; w31..w33=20,21,22; win_row=1, win_col=1.
  - Exactly 24 windows in the frame.
- Row transition -> pixels (3,0) and (3,1) give win_valid=0.
  - Pixel (3,2) gives w11=10, w13=12, w33=32, win_row=2, win_col=1.
- Last pixel (5,7) -> win_valid=1 and frame_done=1 with w11=35, w22=46, w33=57.
  - A following pixel with sof=1 is treated as (0,0); no window until (2,2) again.
- Random pix_valid bubbles (~40% idle) -> window sequence and coordinates identical to the continuous run.
  - Outputs hold during idle cycles; win_valid is never high on two cycles for one accept.
- sof asserted at pixel (3,4) mid-frame -> counters resync to (0,0).
  - No frame_done for the aborted frame.
  - The next full frame produces 24 correct windows.
- rst_n pulsed low asynchronously mid-row -> all outputs 0 immediately.
  - After release, stream restarts at (0,0); the first window is at (2,2) with correct values.

Source files
------------

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streaming 3x3 neighbourhood generator with two line buffers.
// Ports: clk, rst_n (async, active low); pix_in/pix_valid/sof raster input;
//        w11..w33 registered window, win_valid strobe, win_row/win_col
//        centre coordinates, frame_done pulse on the last window of a frame.
module window_gen_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = 8,
    parameter int CW         = $clog2(IMG_WIDTH),
    parameter int RW         = $clog2(IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] w11,
    output logic [DATA_W-1:0] w12,
    output logic [DATA_W-1:0] w13,
    output logic [DATA_W-1:0] w21,
    output logic [DATA_W-1:0] w22,
    output logic [DATA_W-1:0] w23,
    output logic [DATA_W-1:0] w31,
    output logic [DATA_W-1:0] w32,
    output logic [DATA_W-1:0] w33,
    output logic              win_valid,
    output logic [RW-1:0]     win_row,
    output logic [CW-1:0]     win_col,
    output logic              frame_done
);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    // Line buffers are deliberately not reset: the first two lines of a
    // frame never produce a window, so their stale contents are never seen.
    logic [DATA_W-1:0] lb1_mem [IMG_WIDTH];
    logic [DATA_W-1:0] lb2_mem [IMG_WIDTH];

    logic [RW-1:0]     row_q, row_d, pos_r;
    logic [CW-1:0]     col_q, col_d, pos_c;
    logic [DATA_W-1:0] lb1_rd, lb2_rd;
    logic              last_col, last_row, win_ok;

    logic [DATA_W-1:0] win_q [9];
    logic              win_valid_q, frame_done_q;
    logic [RW-1:0]     win_row_q;
    logic [CW-1:0]     win_col_q;

    // sof relabels the current pixel as (0,0), overriding any wrap.
    always_comb begin
        pos_r    = sof ? '0 : row_q;
        pos_c    = sof ? '0 : col_q;
        last_col = (pos_c == COL_LAST);
        last_row = (pos_r == ROW_LAST);
        win_ok   = (pos_r >= RW'(2)) && (pos_c >= CW'(2));
        col_d    = pos_c + CW'(1);
        row_d    = pos_r;
        if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : pos_r + RW'(1);
        end
        lb1_rd = lb1_mem[pos_c];
        lb2_rd = lb2_mem[pos_c];
    end

    // Read-before-write: lb2 takes the old lb1 value at the same column.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1_mem[pos_c] <= pix_in;
            lb2_mem[pos_c] <= lb1_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q        <= '0;
            col_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else if (pix_valid) begin
            row_q        <= row_d;
            col_q        <= col_d;
            win_valid_q  <= win_ok;
            frame_done_q <= last_row && last_col;
            win_q[0]     <= win_q[1];
            win_q[1]     <= win_q[2];
            win_q[2]     <= lb2_rd;
            win_q[3]     <= win_q[4];
            win_q[4]     <= win_q[5];
            win_q[5]     <= lb1_rd;
            win_q[6]     <= win_q[7];
            win_q[7]     <= win_q[8];
            win_q[8]     <= pix_in;
            // Coordinates track the last presented window only.
            if (win_ok) begin
                win_row_q <= pos_r - RW'(1);
                win_col_q <= pos_c - CW'(1);
            end
        end else begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end
    end

    assign w11        = win_q[0];
    assign w12        = win_q[1];
    assign w13        = win_q[2];
    assign w21        = win_q[3];
    assign w22        = win_q[4];
    assign w23        = win_q[5];
    assign w31        = win_q[6];
    assign w32        = win_q[7];
    assign w33        = win_q[8];
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: randomized and directed bench for window_gen_3x3
// against an image-array reference model.
module tb_window_gen_3x3;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       sof;
    logic [7:0] w11, w12, w13, w21, w22, w23, w31, w32, w33;
    logic       win_valid, frame_done;
    logic [2:0] win_row, win_col;

    window_gen_3x3 #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DATA_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .sof       (sof),
        .w11       (w11),
        .w12       (w12),
        .w13       (w13),
        .w21       (w21),
        .w22       (w22),
        .w23       (w23),
        .w31       (w31),
        .w32       (w32),
        .w33       (w33),
        .win_valid (win_valid),
        .win_row   (win_row),
        .win_col   (win_col),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the frame as a 2D image; a window is simply the
    // 3x3 block of the image ending at the accepted pixel.
    int img [H][W];
    int m_r = 0, m_c = 0, r_t, c_t;
    int e_w [9];
    int e_valid = 0, e_fd = 0, e_row = 0, e_col = 0;
    bit e_known = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r = 0; m_c = 0;
            for (int i = 0; i < 9; i++) e_w[i] = 0;
            e_valid = 0; e_fd = 0; e_row = 0; e_col = 0;
            e_known = 1'b1;
        end else begin
            e_valid = 0;
            e_fd = 0;
            if (pix_valid === 1'b1) begin
                r_t = (sof === 1'b1) ? 0 : m_r;
                c_t = (sof === 1'b1) ? 0 : m_c;
                img[r_t][c_t] = int'(pix_in);
                if (r_t >= 2 && c_t >= 2) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            e_w[i*3+j] = img[r_t-2+i][c_t-2+j];
                    e_valid = 1;
                    e_row = r_t - 1;
                    e_col = c_t - 1;
                    e_fd = (r_t == H-1 && c_t == W-1) ? 1 : 0;
                    e_known = 1'b1;
                end else begin
                    e_known = 1'b0;
                end
                c_t++;
                if (c_t == W) begin
                    c_t = 0;
                    r_t = (r_t == H-1) ? 0 : r_t + 1;
                end
                m_r = r_t;
                m_c = c_t;
            end
        end
    end

    int dut_wins = 0, dut_fds = 0;
    int dw [9];

    always @(negedge clk) begin
        chk("win_valid", int'(win_valid), e_valid);
        chk("frame_done", int'(frame_done), e_fd);
        if (win_valid === 1'b1) dut_wins++;
        if (frame_done === 1'b1) dut_fds++;
        if (e_known) begin
            dw[0] = w11; dw[1] = w12; dw[2] = w13;
            dw[3] = w21; dw[4] = w22; dw[5] = w23;
            dw[6] = w31; dw[7] = w32; dw[8] = w33;
            for (int i = 0; i < 9; i++) chk($sformatf("win[%0d]", i), dw[i], e_w[i]);
            chk("win_row", int'(win_row), e_row);
            chk("win_col", int'(win_col), e_col);
        end
    end

    task automatic step(input logic v, input logic s, input logic [7:0] p);
        @(negedge clk);
        pix_valid = v;
        sof = s;
        pix_in = p;
    endtask

    task automatic bubbles(input int pct);
        while (int'($urandom_range(0, 99)) < pct)
            step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    int n0, fd0;
    int vals [H][W];

    initial begin
        rst_n = 1'b0;
        pix_valid = 1'b0;
        sof = 1'b0;
        pix_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_win_valid", int'(win_valid), 0);
        chk("rst_w22", int'(w22), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_win_col", int'(win_col), 0);
        rst_n = 1'b1;

        // Frame A: continuous, pixel = row*16+col
        n0 = dut_wins; fd0 = dut_fds;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, 1'(r == 0 && c == 0), 8'(r*16 + c));
                if (r == 2 && c == 2) begin
                    settle();
                    chk("A22_valid", int'(win_valid), 1);
                    chk("A22_w11", int'(w11), 'h00);
                    chk("A22_w12", int'(w12), 'h01);
                    chk("A22_w13", int'(w13), 'h02);
                    chk("A22_w21", int'(w21), 'h10);
                    chk("A22_w22", int'(w22), 'h11);
                    chk("A22_w23", int'(w23), 'h12);
                    chk("A22_w31", int'(w31), 'h20);
                    chk("A22_w32", int'(w32), 'h21);
                    chk("A22_w33", int'(w33), 'h22);
                    chk("A22_row", int'(win_row), 1);
                    chk("A22_col", int'(win_col), 1);
                end
                if (r == 3 && c < 2) begin
                    settle();
                    chk("A3x_valid", int'(win_valid), 0);
                end
                if (r == 3 && c == 2) begin
                    settle();
                    chk("A32_w11", int'(w11), 'h10);
                    chk("A32_w13", int'(w13), 'h12);
                    chk("A32_w33", int'(w33), 'h32);
                    chk("A32_row", int'(win_row), 2);
                    chk("A32_col", int'(win_col), 1);
                end
                if (r == H-1 && c == W-1) begin
                    settle();
                    chk("A57_valid", int'(win_valid), 1);
                    chk("A57_fd", int'(frame_done), 1);
                    chk("A57_w11", int'(w11), 'h35);
                    chk("A57_w22", int'(w22), 'h46);
                    chk("A57_w33", int'(w33), 'h57);
                end
            end
        end

        // Frame B: immediately following sof pixel, then ~40% bubbles
        step(1'b1, 1'b1, 8'h00);
        settle();
        chk("B00_valid", int'(win_valid), 0);
        chk("B00_fd", int'(frame_done), 0);
        chk("A_windows", dut_wins - n0, 24);
        chk("A_frame_done", dut_fds - fd0, 1);
        n0 = dut_wins; fd0 = dut_fds;
        for (int k = 1; k < W*H; k++) begin
            bubbles(40);
            step(1'b1, 1'b0, 8'((k / W)*16 + (k % W)));
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("B_windows", dut_wins - n0, 24);
        chk("B_frame_done", dut_fds - fd0, 1);

        // Frame C: random data, sof again at position (3,4)
        fd0 = dut_fds;
        for (int k = 0; k < 3*W + 4; k++) begin
            bubbles(40);
            step(1'b1, 1'(k == 0), 8'($urandom));
        end
        bubbles(40);
        step(1'b1, 1'b1, 8'($urandom));
        settle();
        chk("C_sof_valid", int'(win_valid), 0);
        chk("C_abort_fd", dut_fds - fd0, 0);
        n0 = dut_wins;
        for (int k = 1; k < W*H; k++) begin
            bubbles(40);
            step(1'b1, 1'b0, 8'($urandom));
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("C_windows", dut_wins - n0, 24);
        chk("C_frame_done", dut_fds - fd0, 1);

        // Frame D: asynchronous reset mid-row
        for (int k = 0; k < 3*W + 5; k++)
            step(1'b1, 1'(k == 0), 8'($urandom_range(1, 255)));
        settle();
        chk("D34_valid", int'(win_valid), 1);
        pix_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("D_rst_valid", int'(win_valid), 0);
        chk("D_rst_w33", int'(w33), 0);
        chk("D_rst_w11", int'(w11), 0);
        chk("D_rst_row", int'(win_row), 0);
        chk("D_rst_col", int'(win_col), 0);
        chk("D_rst_fd", int'(frame_done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Frame E: restart without sof, first window at (2,2)
        n0 = dut_wins; fd0 = dut_fds;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                vals[r][c] = int'($urandom_range(0, 255));
                step(1'b1, 1'b0, 8'(vals[r][c]));
                if (r == 2 && c == 2) begin
                    settle();
                    chk("E22_valid", int'(win_valid), 1);
                    chk("E22_row", int'(win_row), 1);
                    chk("E22_col", int'(win_col), 1);
                    chk("E22_w11", int'(w11), vals[0][0]);
                    chk("E22_w23", int'(w23), vals[1][2]);
                    chk("E22_w33", int'(w33), vals[2][2]);
                end
            end
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("E_windows", dut_wins - n0, 24);
        chk("E_frame_done", dut_fds - fd0, 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
